// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared types and constants for the SPI-to-RAM subsystem
package spi_ram_pkg;

  localparam int SPI_ADDR_W = 8;
  localparam int SPI_WORD_W = SPI_ADDR_W + 2;

  // Opcodes carried in rx_data[9:8]; decoded by the RAM, not by the slave
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - loads one RAM read byte and shifts it out MSB first on MISO
module spi_tx_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         dout
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             busy;

  // MSB goes straight to dout on load; remaining bits follow one per clock, then dout parks at 0
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      dout    <= 1'b0;
    end else if (load && !busy) begin
      shreg   <= {din[W-2:0], 1'b0};
      bit_cnt <= '0;
      busy    <= 1'b1;
      dout    <= din[W-1];
    end else if (busy) begin
      if (bit_cnt == CNT_W'(W - 1)) begin
        busy <= 1'b0;
        dout <= 1'b0;
      end else begin
        dout    <= shreg[W-1];
        shreg   <= {shreg[W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave front end: MOSI command deserialiser and MISO read-data return
module spi_slave
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int WORD_W = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [ADDR_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int CNT_W = $clog2(WORD_W);

  spi_state_e        state, state_nxt;
  logic [WORD_W-2:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_done;
  logic              rd_addr_seen;
  logic              tx_taken;
  logic              shift_en;
  logic              word_last;
  logic              awaiting;
  logic              tx_load;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and shift enable; deselect always returns to IDLE
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: shift_en = !word_done;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign word_last = shift_en && (bit_cnt == CNT_W'(WORD_W - 1));
  // Only one RAM response is accepted per read-data frame, and only after its word is out
  assign awaiting  = (state == READ_DATA) && word_done && !tx_taken;
  assign tx_load   = tx_valid && awaiting;

  // Word assembly, completion strobe and read-address bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift     <= '0;
      bit_cnt      <= '0;
      word_done    <= 1'b0;
      tx_taken     <= 1'b0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        rx_shift  <= '0;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        tx_taken  <= 1'b0;
      end else begin
        if (shift_en) begin
          rx_shift <= {rx_shift[WORD_W-3:0], MOSI};
          bit_cnt  <= bit_cnt + 1'b1;
          if (word_last) begin
            rx_data   <= {rx_shift, MOSI};
            rx_valid  <= 1'b1;
            word_done <= 1'b1;
            if (state == READ_ADD)       rd_addr_seen <= 1'b1;
            else if (state == READ_DATA) rd_addr_seen <= 1'b0;
          end
        end
        if (tx_load) tx_taken <= 1'b1;
      end
    end
  end

  spi_tx_serializer #(.W(ADDR_W)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (SS_n),
    .load  (tx_load),
    .din   (tx_data),
    .dout  (MISO)
  );

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;

  localparam int AW = 8;
  localparam int WW = 10;
  localparam int NC = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SS_n = 1'b0;
  logic          MOSI = 1'b0;
  logic          tx_valid = 1'b0;
  logic [AW-1:0] tx_data = '0;
  logic          MISO;
  logic          rx_valid;
  logic [WW-1:0] rx_data;

  spi_slave #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  // Frame-level model: expected outputs per cycle index, filled in by the stimulus
  bit            exp_valid [NC];
  logic [WW-1:0] exp_word  [NC];
  bit            exp_miso  [NC];
  bit            m_seen = 1'b0;
  logic [WW-1:0] m_rxd = '0;
  int            tests = 0;
  int            fails = 0;
  int            pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare every cycle against the model
  always @(negedge clk) begin
    if (cyc > 0 && cyc < NC) begin
      if (!rst_seen)           m_rxd = '0;
      else if (exp_valid[cyc]) m_rxd = exp_word[cyc];
      chk("rx_valid", 32'(rx_valid), 32'(exp_valid[cyc]));
      chk("rx_data", 32'(rx_data), 32'(m_rxd));
      chk("miso", 32'(MISO), 32'(exp_miso[cyc]));
      if (rx_valid === 1'b1) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One framed transaction: dummy IDLE cycle, select bit, nbits of w, extra bits, optional RAM reply
  task automatic frame(input bit sel, input logic [WW-1:0] w, input int nbits, input int extra,
                       input bit tx_en, input logic [AW-1:0] txd, input int keep, input bit stray,
                       output logic [AW-1:0] got);
    int n, t, nk, nt;
    bit rd;
    n   = cyc;
    got = '0;
    rd  = sel && m_seen;
    if (nbits == WW) begin
      exp_valid[n+12] = 1'b1;
      exp_word[n+12]  = w;
    end
    SS_n = 1'b0; MOSI = 1'b0; tick();
    MOSI = sel; tick();
    for (int i = 0; i < nbits; i++) begin
      MOSI     = w[WW-1-i];
      tx_valid = stray && (i == 3);
      tx_data  = txd;
      tick();
    end
    tx_valid = 1'b0;
    if (nbits == WW) begin
      if (sel) m_seen = !m_seen;
      for (int k = 0; k < extra; k++) begin
        MOSI = k[0];
        tick();
      end
      if (tx_en) begin
        tx_valid = 1'b1; tx_data = txd;
        t = cyc + 1;
        tick();
        nk = (keep < 8) ? keep : 8;
        nt = (keep < 8) ? keep - 1 : 10;
        for (int k = 0; k <= nt; k++) begin
          if (k < nk) begin
            got = {got[AW-2:0], MISO};
            if (rd) exp_miso[t+k] = txd[7-k];
          end
          if (k == nt) break;
          tx_valid = (k == 2);
          tx_data  = (k == 2) ? ~txd : txd;
          tick();
        end
        tx_valid = 1'b0;
      end
    end
    SS_n = 1'b1; MOSI = 1'b0; tick();
    tick();
  endtask

  logic [AW-1:0] got;
  int            p0;

  initial begin
    rst_n = 1'b0; SS_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      MOSI = i[0];
      tick();
    end
    chk("reset_miso", 32'(MISO), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    SS_n = 1'b1; rst_n = 1'b1; MOSI = 1'b0;
    tick(); tick();

    frame(1'b1, 10'h2A5, 10, 0, 1'b1, 8'h77, 8, 1'b0, got);
    chk("rd_addr_word", 32'(rx_data), 32'h2A5);
    chk("rd_addr_no_miso", 32'(got), 32'h00);

    p0 = pulses;
    frame(1'b0, 10'h0A5, 10, 5, 1'b0, 8'h00, 8, 1'b0, got);
    chk("wr_addr_word", 32'(rx_data), 32'h0A5);
    chk("wr_addr_one_pulse", 32'(pulses - p0), 32'd1);

    frame(1'b0, 10'h13C, 10, 0, 1'b1, 8'hFF, 8, 1'b1, got);
    chk("wr_data_word", 32'(rx_data), 32'h13C);
    chk("stray_tx_ignored", 32'(got), 32'h00);

    frame(1'b1, 10'h300, 10, 0, 1'b1, 8'hC3, 8, 1'b0, got);
    chk("rd_data_word", 32'(rx_data), 32'h300);
    chk("rd_data_miso", 32'(got), 32'hC3);

    p0 = pulses;
    frame(1'b0, 10'h3FF, 6, 0, 1'b0, 8'h00, 8, 1'b0, got);
    chk("abort_no_pulse", 32'(pulses - p0), 32'd0);
    chk("abort_rx_hold", 32'(rx_data), 32'h300);

    frame(1'b0, 10'h155, 10, 0, 1'b0, 8'h00, 8, 1'b0, got);
    chk("after_abort_word", 32'(rx_data), 32'h155);

    frame(1'b1, 10'h2FF, 10, 0, 1'b0, 8'h00, 8, 1'b0, got);

    // Reset inside a read-data frame must forget the pending read address
    SS_n = 1'b0; MOSI = 1'b0; tick();
    MOSI = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      tick();
    end
    rst_n = 1'b0; m_seen = 1'b0;
    tick(); tick();
    SS_n = 1'b1; rst_n = 1'b1;
    tick(); tick();
    chk("midreset_rx_data", 32'(rx_data), 32'h0);

    frame(1'b1, 10'h2AA, 10, 0, 1'b1, 8'h3C, 8, 1'b0, got);
    chk("post_reset_rd_addr", 32'(got), 32'h00);

    frame(1'b1, 10'h3AA, 10, 0, 1'b1, 8'h96, 3, 1'b0, got);
    chk("truncated_miso", 32'(got), 32'h4);

    frame(1'b1, 10'h3C3, 10, 0, 1'b1, 8'hA5, 8, 1'b0, got);
    chk("seen_cleared", 32'(got), 32'h00);

    frame(1'b1, 10'h301, 10, 0, 1'b1, 8'h5A, 8, 1'b0, got);
    chk("rd_data_miso2", 32'(got), 32'h5A);
    chk("rd_data_word2", 32'(rx_data), 32'h301);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
